// File: rtl/des_round_if.sv
// des_round_if: host/datapath control bundle for des_round_ctrl.
//   master : requester side (drives in_valid, in_decrypt, out_ready[, abort])
//   slave  : controller side (drives in_ready, stage enables, key-schedule
//            controls, out_valid, busy[, abort_ack])
// Optional abort signals exist only when DES_ABORT_EN is defined.
interface des_round_if;
  logic       in_valid;
  logic       in_decrypt;
  logic       in_ready;
  logic       ip_load;
  logic       round_en;
  logic [3:0] round_idx;
  logic [1:0] ks_shift;
  logic       ks_dir;
  logic       fp_start;
  logic       out_valid;
  logic       out_ready;
  logic       busy;
`ifdef DES_ABORT_EN
  logic       abort;
  logic       abort_ack;

  modport master (
    output in_valid, in_decrypt, out_ready, abort,
    input  in_ready, ip_load, round_en, round_idx, ks_shift, ks_dir,
           fp_start, out_valid, busy, abort_ack
  );
  modport slave (
    input  in_valid, in_decrypt, out_ready, abort,
    output in_ready, ip_load, round_en, round_idx, ks_shift, ks_dir,
           fp_start, out_valid, busy, abort_ack
  );
`else
  modport master (
    output in_valid, in_decrypt, out_ready,
    input  in_ready, ip_load, round_en, round_idx, ks_shift, ks_dir,
           fp_start, out_valid, busy
  );
  modport slave (
    input  in_valid, in_decrypt, out_ready,
    output in_ready, ip_load, round_en, round_idx, ks_shift, ks_dir,
           fp_start, out_valid, busy
  );
`endif
endinterface

// File: rtl/des_round_ctrl.sv
// des_round_ctrl: sequences one DES block through IP, ROUNDS Feistel rounds
// with key-schedule shift control, then the inverse permutation, and returns
// a result-valid handshake. Holds no data.
// Ports:
//   clk, rst_n (async active-low)
//   bus (des_round_if.slave): in_valid/in_decrypt/in_ready request handshake,
//     ip_load, round_en, round_idx, ks_shift, ks_dir, fp_start stage controls,
//     out_valid/out_ready result handshake, busy.
// Build option DES_ABORT_EN adds bus.abort / bus.abort_ack.
// All outputs are registered, decoded from next-state and next round count.
module des_round_ctrl #(
  parameter int unsigned ROUNDS = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  des_round_if.slave  bus
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] LAST_RND = CNT_W'(ROUNDS - 1);

  typedef enum logic [2:0] {S_IDLE, S_IP, S_ROUND, S_FP, S_DONE} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] rcnt_q, rcnt_d;
  logic             mode_q, mode_d;

  logic             in_ready_q, in_ready_d;
  logic             ip_load_q, ip_load_d;
  logic             round_en_q, round_en_d;
  logic [CNT_W-1:0] round_idx_q, round_idx_d;
  logic [1:0]       ks_shift_q, ks_shift_d;
  logic             ks_dir_q, ks_dir_d;
  logic             fp_start_q, fp_start_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;
`ifdef DES_ABORT_EN
  logic             abort_ack_q, abort_ack_d;
`endif

  // Rotate amount for round r. Decrypt rotates right after use, so its
  // first round applies no shift and K16 (= PC-1 key) is used directly.
  function automatic logic [1:0] shift_amt(input logic [CNT_W-1:0] r,
                                           input logic dec);
    logic [1:0] s;
    if (r == 4'd0 || r == 4'd1 || r == 4'd8 || r == 4'd15) s = 2'd1;
    else                                                   s = 2'd2;
    if (dec && r == 4'd0) s = 2'd0;
    return s;
  endfunction

  // Next-state and next-output decode
  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    mode_d  = mode_q;
`ifdef DES_ABORT_EN
    abort_ack_d = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        // in_ready_q gates the accept so nothing is taken in the first
        // cycle after reset release, when in_ready is still low.
        if (in_ready_q && bus.in_valid) begin
          mode_d  = bus.in_decrypt;
          state_d = S_IP;
        end
      end
      S_IP: begin
        rcnt_d  = '0;
        state_d = S_ROUND;
      end
      S_ROUND: begin
        if (rcnt_q == LAST_RND) begin
          rcnt_d  = '0;
          state_d = S_FP;
        end else begin
          rcnt_d = rcnt_q + CNT_W'(1);
        end
      end
      S_FP:    state_d = S_DONE;
      S_DONE:  if (bus.out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

`ifdef DES_ABORT_EN
    if (bus.abort && (state_q == S_IP || state_q == S_ROUND || state_q == S_FP)) begin
      state_d     = S_IDLE;
      rcnt_d      = '0;
      abort_ack_d = 1'b1;
    end
`endif

    in_ready_d  = (state_d == S_IDLE);
    ip_load_d   = (state_d == S_IP);
    round_en_d  = (state_d == S_ROUND);
    round_idx_d = (state_d == S_ROUND) ? rcnt_d : '0;
    ks_shift_d  = (state_d == S_ROUND) ? shift_amt(rcnt_d, mode_d) : 2'd0;
    ks_dir_d    = (state_d == S_ROUND) && mode_d;
    fp_start_d  = (state_d == S_FP);
    out_valid_d = (state_d == S_DONE);
    busy_d      = (state_d != S_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      rcnt_q      <= '0;
      mode_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      ip_load_q   <= 1'b0;
      round_en_q  <= 1'b0;
      round_idx_q <= '0;
      ks_shift_q  <= 2'd0;
      ks_dir_q    <= 1'b0;
      fp_start_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef DES_ABORT_EN
      abort_ack_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      rcnt_q      <= rcnt_d;
      mode_q      <= mode_d;
      in_ready_q  <= in_ready_d;
      ip_load_q   <= ip_load_d;
      round_en_q  <= round_en_d;
      round_idx_q <= round_idx_d;
      ks_shift_q  <= ks_shift_d;
      ks_dir_q    <= ks_dir_d;
      fp_start_q  <= fp_start_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
`ifdef DES_ABORT_EN
      abort_ack_q <= abort_ack_d;
`endif
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.ip_load   = ip_load_q;
  assign bus.round_en  = round_en_q;
  assign bus.round_idx = round_idx_q;
  assign bus.ks_shift  = ks_shift_q;
  assign bus.ks_dir    = ks_dir_q;
  assign bus.fp_start  = fp_start_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
`ifdef DES_ABORT_EN
  assign bus.abort_ack = abort_ack_q;
`endif

endmodule
